// File: rtl/decrypt_mux_packer.sv
// rtl/decrypt_mux_packer.sv - channel select and byte-to-word packer at the decryption output
//
// Purpose: selects one of three decryptor byte channels and packs its bytes
// MSB-first into words. A full word is emitted on its last byte. A partial
// word is flushed when the channel changes or when the channel stays idle.
// Every output is registered.
//
// Ports:
//   clk_sys                   system clock (rising edge)
//   rst_n                     asynchronous active-low reset
//   select                    channel select 0..2, 3 = no channel
//   data0_i..data2_i          decryptor bytes
//   valid0_i..valid2_i        byte qualifiers
//   data_o                    packed word, first byte in the MSBs
//   valid_o                   one-cycle pulse per emitted word
//   bytes_o                   valid bytes in data_o (1..4), 0 when idle
//   drop_o                    one-cycle pulse: byte seen on a non-selected channel
//   word_cnt_o                emitted word counter (wraps)
module decrypt_mux_packer #(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8,
  parameter int IDLE_FLUSH = 8
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [1:0]            select,
  input  logic [SYS_DWIDTH-1:0] data0_i,
  input  logic [SYS_DWIDTH-1:0] data1_i,
  input  logic [SYS_DWIDTH-1:0] data2_i,
  input  logic                  valid0_i,
  input  logic                  valid1_i,
  input  logic                  valid2_i,
  output logic [MST_DWIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic [2:0]            bytes_o,
  output logic                  drop_o,
  output logic [15:0]           word_cnt_o
);

  localparam int IW    = $clog2(IDLE_FLUSH);
  localparam int LANES = MST_DWIDTH / SYS_DWIDTH;

  logic [MST_DWIDTH-1:0] acc;
  logic [1:0]            cnt;
  logic [1:0]            sel_q;
  logic [IW-1:0]         idle_cnt;

  logic                  sv;
  logic [SYS_DWIDTH-1:0] sel_byte;
  logic                  drop_c;
  logic                  switch_flush;
  logic [MST_DWIDTH-1:0] acc_ins;
  logic [MST_DWIDTH-1:0] first_word;

  always_comb begin
    sv       = 1'b0;
    sel_byte = '0;
    case (select)
      2'd0: begin sv = valid0_i; sel_byte = data0_i; end
      2'd1: begin sv = valid1_i; sel_byte = data1_i; end
      2'd2: begin sv = valid2_i; sel_byte = data2_i; end
      default: begin sv = 1'b0; sel_byte = '0; end
    endcase

    // With select=3 every channel counts as non-selected.
    drop_c = (valid0_i && (select != 2'd0)) ||
             (valid1_i && (select != 2'd1)) ||
             (valid2_i && (select != 2'd2));

    // A select change only matters when there is a partial word to flush.
    switch_flush = (select != sel_q) && (cnt != 2'd0);

    // Accumulator with the incoming byte dropped into lane cnt.
    acc_ins = acc;
    for (int i = 0; i < LANES; i++) begin
      if (cnt == 2'(i)) begin
        acc_ins[MST_DWIDTH-1-SYS_DWIDTH*i -: SYS_DWIDTH] = sel_byte;
      end
    end

    first_word = {sel_byte, {(MST_DWIDTH-SYS_DWIDTH){1'b0}}};
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= 2'd0;
      sel_q      <= 2'd0;
      idle_cnt   <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      bytes_o    <= 3'd0;
      drop_o     <= 1'b0;
      word_cnt_o <= 16'd0;
    end else begin
      sel_q   <= select;
      drop_o  <= drop_c;
      valid_o <= 1'b0;
      bytes_o <= 3'd0;

      if (switch_flush) begin
        // Unfilled low lanes of acc are already zero because acc clears
        // after every emission.
        data_o     <= acc;
        bytes_o    <= {1'b0, cnt};
        valid_o    <= 1'b1;
        word_cnt_o <= word_cnt_o + 16'd1;
        idle_cnt   <= '0;
        if (sv) begin
          acc <= first_word;
          cnt <= 2'd1;
        end else begin
          acc <= '0;
          cnt <= 2'd0;
        end
      end else if (sv) begin
        idle_cnt <= '0;
        if (cnt == 2'd3) begin
          data_o     <= acc_ins;
          bytes_o    <= 3'd4;
          valid_o    <= 1'b1;
          word_cnt_o <= word_cnt_o + 16'd1;
          acc        <= '0;
          cnt        <= 2'd0;
        end else begin
          acc <= acc_ins;
          cnt <= cnt + 2'd1;
        end
      end else if (cnt != 2'd0) begin
        if (idle_cnt == IW'(IDLE_FLUSH-1)) begin
          data_o     <= acc;
          bytes_o    <= {1'b0, cnt};
          valid_o    <= 1'b1;
          word_cnt_o <= word_cnt_o + 16'd1;
          acc        <= '0;
          cnt        <= 2'd0;
          idle_cnt   <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_decrypt_mux_packer.sv
// tb/tb_decrypt_mux_packer.sv - scoreboard testbench for decrypt_mux_packer
module tb_decrypt_mux_packer;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [1:0]  select;
  logic [7:0]  data0_i, data1_i, data2_i;
  logic        valid0_i, valid1_i, valid2_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic [2:0]  bytes_o;
  logic        drop_o;
  logic [15:0] word_cnt_o;

  always #5 clk_sys = ~clk_sys;

  decrypt_mux_packer #(
    .MST_DWIDTH(32),
    .SYS_DWIDTH(8),
    .IDLE_FLUSH(8)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .select    (select),
    .data0_i   (data0_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .valid0_i  (valid0_i),
    .valid1_i  (valid1_i),
    .valid2_i  (valid2_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .bytes_o   (bytes_o),
    .drop_o    (drop_o),
    .word_cnt_o(word_cnt_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic [15:0] wc;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];
  int   exp_wc = 0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   k;

  always @(posedge clk_sys) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle of inputs: v[i] qualifies channel i, all channels carry b.
  task automatic step(input logic [1:0] s, input logic [2:0] v, input logic [7:0] b);
    select   = s;
    valid0_i = v[0];
    valid1_i = v[1];
    valid2_i = v[2];
    data0_i  = b;
    data1_i  = b;
    data2_i  = b;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] n, input int at);
    exp_t e;
    exp_wc++;
    e.data   = d;
    e.nbytes = n;
    e.wc     = exp_wc[15:0];
    e.at     = at;
    exp_q.push_back(e);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_data"},  data_o,             32'h0);
    chk({tag, "_valid"}, {31'd0, valid_o},   32'h0);
    chk({tag, "_bytes"}, {29'd0, bytes_o},   32'h0);
    chk({tag, "_drop"},  {31'd0, drop_o},    32'h0);
    chk({tag, "_wcnt"},  {16'd0, word_cnt_o}, 32'h0);
  endtask

  // Monitor: compares every emitted word and drop pulse against the queues.
  always @(negedge clk_sys) begin
    if (rst_n === 1'b1) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word actual=0x%08h required=none (cycle %0d)", data_o, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_data",  data_o,              e.data);
          chk("word_bytes", {29'd0, bytes_o},    {29'd0, e.nbytes});
          chk("word_cnt",   {16'd0, word_cnt_o}, {16'd0, e.wc});
          chk("word_cycle", cyc,                 e.at);
        end
      end else begin
        chk("bytes_idle", {29'd0, bytes_o}, 32'h0);
      end
      if (drop_o) begin
        if (drop_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_drop actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          chk("drop_cycle", cyc, drop_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    select = 2'd0;
    valid0_i = 1'b0; valid1_i = 1'b0; valid2_i = 1'b0;
    data0_i = 8'h0;  data1_i = 8'h0;  data2_i = 8'h0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step(2'd0, 3'b000, 8'h00);

    // 1: one full word on channel 0
    k = cyc;
    expect_word(32'hDEADBEEF, 3'd4, k + 4);
    step(2'd0, 3'b001, 8'hDE);
    step(2'd0, 3'b001, 8'hAD);
    step(2'd0, 3'b001, 8'hBE);
    step(2'd0, 3'b001, 8'hEF);
    repeat (3) step(2'd0, 3'b000, 8'h00);

    // 2: back-to-back bytes on channel 1, two words four cycles apart
    k = cyc;
    expect_word(32'h01020304, 3'd4, k + 4);
    expect_word(32'h05060708, 3'd4, k + 8);
    for (int i = 1; i <= 8; i++) step(2'd1, 3'b010, 8'(i));
    repeat (2) step(2'd1, 3'b000, 8'h00);

    // 3: partial word on channel 2 flushed by idle timeout
    k = cyc;
    expect_word(32'hAABB0000, 3'd2, k + 1 + 9);
    step(2'd2, 3'b100, 8'hAA);
    step(2'd2, 3'b100, 8'hBB);
    repeat (12) step(2'd2, 3'b000, 8'h00);

    // 4: switch flush with a new-channel byte in the switch cycle
    k = cyc;
    expect_word(32'h11223300, 3'd3, k + 4);
    expect_word(32'h44556677, 3'd4, k + 7);
    step(2'd0, 3'b001, 8'h11);
    step(2'd0, 3'b001, 8'h22);
    step(2'd0, 3'b001, 8'h33);
    step(2'd1, 3'b010, 8'h44);
    step(2'd1, 3'b010, 8'h55);
    step(2'd1, 3'b010, 8'h66);
    step(2'd1, 3'b010, 8'h77);
    repeat (2) step(2'd1, 3'b000, 8'h00);

    // 5: drops on a non-selected channel and with select=3
    k = cyc;
    drop_q.push_back(k + 2);
    expect_word(32'hC1C2C3C4, 3'd4, k + 5);
    drop_q.push_back(k + 6);
    step(2'd0, 3'b001, 8'hC1);
    step(2'd0, 3'b010, 8'h99);
    step(2'd0, 3'b001, 8'hC2);
    step(2'd0, 3'b001, 8'hC3);
    step(2'd0, 3'b001, 8'hC4);
    step(2'd3, 3'b001, 8'h55);
    repeat (12) step(2'd0, 3'b000, 8'h00);

    // 6: reset mid-word discards the partial word
    step(2'd0, 3'b001, 8'h10);
    step(2'd0, 3'b001, 8'h20);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    exp_wc = 0;
    repeat (2) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    step(2'd0, 3'b000, 8'h00);
    k = cyc;
    expect_word(32'hA1A2A3A4, 3'd4, k + 4);
    step(2'd0, 3'b001, 8'hA1);
    step(2'd0, 3'b001, 8'hA2);
    step(2'd0, 3'b001, 8'hA3);
    step(2'd0, 3'b001, 8'hA4);
    repeat (12) step(2'd0, 3'b000, 8'h00);

    chk("words_pending", exp_q.size(), 32'd0);
    chk("drops_pending", drop_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decrypt_mux_packer.md
# decrypt_mux_packer

- Output stage of the decryption datapath, fed by the three 8-bit decryptor channels.
- Selects one channel and packs its bytes MSB-first into 32-bit words, the inverse of the upstream word-to-byte split.
- Emits one-cycle word pulses with a byte count, flushing partial words on channel switch or idle timeout.
- Runs entirely in the system clock domain.

## Interface

Parameters:
- MST_DWIDTH, 32, output word width; must equal 4*SYS_DWIDTH.
- SYS_DWIDTH, 8, input byte width.
- IDLE_FLUSH, 8, consecutive idle cycles (≥2) after which a partial word is flushed.

Ports:
- clk_sys  in  1  system clock; the only clock. All logic is on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- select  in  2  channel select: 0/1/2 = channel 0/1/2; 3 = no channel.
- data0_i, data1_i, data2_i  in  SYS_DWIDTH each  decryptor output bytes.
- valid0_i, valid1_i, valid2_i  in  1 each  byte-valid qualifiers.
- data_o  out  MST_DWIDTH  packed word; first byte in [31:24].
- valid_o  out  1  one-cycle pulse per emitted word.
- bytes_o  out  3  number of valid bytes in data_o (1..4); 0 when valid_o=0.
- drop_o  out  1  one-cycle pulse: a byte was presented on a non-selected channel.
- word_cnt_o  out  16  count of emitted words; wraps at 2^16.

## Operation

- Internal state:
  - acc: 32-bit accumulator.
  - cnt: 0..3, bytes held.
  - sel_q: registered select, reset 0.
  - idle_cnt: counter, 0..IDLE_FLUSH-1.
- Selected valid (sv): valid of the channel given by the current select. If select=3, sv=0.
- Byte accept when sv=1:
  - Byte written to acc[(31-8*cnt) -: 8]; cnt increments.
  - On the 4th byte (cnt=3 before accept), the full word including this byte is loaded to data_o, with valid_o=1 and bytes_o=4.
  - Then acc clears and cnt=0.
- Channel switch: select≠sel_q with cnt>0 flushes the partial word.
  - data_o = acc with unfilled low bytes zero; bytes_o = cnt; valid_o = 1.
  - If sv=1 in the same cycle, that byte on the new channel becomes byte 0 of a fresh word (cnt=1).
  - A switch with cnt=0 does nothing.
  - sel_q <= select every cycle.
- Idle flush:
  - While cnt>0 and sv=0 (and no switch), idle_cnt increments.
  - On the cycle idle_cnt=IDLE_FLUSH-1 and sv=0, the partial word is flushed (same format as above); cnt and idle_cnt clear.
  - Any accepted byte or flush clears idle_cnt. idle_cnt holds 0 while cnt=0.
- drop_o:
  - Pulses when any non-selected valid is high; select=3 with any valid high also pulses it.
  - The dropped byte is ignored.
- word_cnt_o increments on every valid_o pulse, full or partial.
- Precedence in one cycle: switch-flush > 4th-byte complete > idle flush. At most one word is emitted per cycle. A 4th-byte completion cannot coincide with a switch-flush because the switch restarts the word.

## Timing

- Reset values: data_o=0, valid_o=0, bytes_o=0, drop_o=0, word_cnt_o=0; acc=0, cnt=0, idle_cnt=0, sel_q=0.
- Reset asserted mid-word discards the partial word with no flush pulse.
- Latency:
  - valid_o rises on the clock edge that accepts the 4th byte (registered outputs, one cycle after the byte is presented).
  - data_o holds its value until the next emission.
  - bytes_o returns to 0 when valid_o drops.
- Throughput: one byte per cycle with no bubbles; sustained input gives valid_o every 4th cycle.
- Switch flush: valid_o is high the cycle after select changes.
- Idle flush: valid_o is high IDLE_FLUSH cycles after the last accepted byte.
- drop_o is registered: high the cycle after the offending valid.

## Test plan

1. Reset, then select=0 with 4 consecutive bytes 0xDE,0xAD,0xBE,0xEF on channel 0:
   - valid_o pulses once, data_o=0xDEADBEEF, bytes_o=4, word_cnt_o=1.
2. select=1 with 8 back-to-back bytes 0x01..0x08:
   - Two pulses 4 cycles apart: 0x01020304 then 0x05060708.
   - No drop_o.
3. select=2, bytes 0xAA,0xBB, then idle with IDLE_FLUSH=8:
   - Exactly 8 cycles after 0xBB, data_o=0xAABB0000, bytes_o=2.
4. select=0, bytes 0x11,0x22,0x33; switch to select=1 with byte 0x44 valid on channel 1 in the same cycle, then 0x55,0x66,0x77:
   - Flush 0x11223300 with bytes_o=3.
   - Then 0x44556677 with bytes_o=4.
5. select=0 while valid1_i pulses with 0x99, then select=3 with valid0_i high:
   - drop_o pulses for each; acc unchanged; no valid_o.
6. Bytes 0x10,0x20 accepted, then rst_n low mid-word, then release:
   - All outputs 0; no flush pulse.
   - Next 4 bytes form a clean word; word_cnt_o=1.
